// File: rtl/dispatch_credit_ctrl_if.sv
// Dispatch credit bus: dispatcher/unit events in, occupancy and stall flags out.
// DSP_STALL_STATS_EN adds the stall_cyc/stall_cause statistics signals.
interface dispatch_credit_ctrl_if #(
  parameter int unsigned CNT_W = 5
);
  logic             rdy;
  logic             rollback_signal;
  logic             instr_rdy_2rob;
  logic             ena_rs;
  logic             ena_lsb;
  logic             rob_commit;
  logic             rs_issue;
  logic             lsb_issue;
  logic [CNT_W-1:0] lsb_keep_cnt;
  logic             is_full;
  logic             rob_full;
  logic             rs_full;
  logic             lsb_full;
  logic [CNT_W-1:0] rob_cnt;
  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] lsb_cnt;
  logic             err_flag;
`ifdef DSP_STALL_STATS_EN
  logic [31:0]      stall_cyc;
  logic [2:0]       stall_cause;
`endif

  modport slave (
    input  rdy, rollback_signal, instr_rdy_2rob, ena_rs, ena_lsb,
           rob_commit, rs_issue, lsb_issue, lsb_keep_cnt,
    output is_full, rob_full, rs_full, lsb_full, rob_cnt, rs_cnt, lsb_cnt, err_flag
`ifdef DSP_STALL_STATS_EN
    , output stall_cyc, stall_cause
`endif
  );

  modport master (
    output rdy, rollback_signal, instr_rdy_2rob, ena_rs, ena_lsb,
           rob_commit, rs_issue, lsb_issue, lsb_keep_cnt,
    input  is_full, rob_full, rs_full, lsb_full, rob_cnt, rs_cnt, lsb_cnt, err_flag
`ifdef DSP_STALL_STATS_EN
    , input stall_cyc, stall_cause
`endif
  );
endinterface

// File: rtl/dispatch_credit_ctrl.sv
// Occupancy/credit tracker for ROB, RS and LSB; sole source of the dispatcher's is_full stall.
// Optional stall statistics are built when DSP_STALL_STATS_EN is defined.
module dispatch_credit_ctrl #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned LSB_SIZE = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic                  clk,
  input logic                  rst,
  dispatch_credit_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] RobMax = CNT_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0] RsMax  = CNT_W'(RS_SIZE);
  localparam logic [CNT_W-1:0] LsbMax = CNT_W'(LSB_SIZE);

  logic [CNT_W-1:0] rob_cnt_q, rob_cnt_d;
  logic [CNT_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [CNT_W-1:0] lsb_cnt_q, lsb_cnt_d;
  logic             err_q, err_d;
  logic             rob_full, rs_full, lsb_full, is_full;
  logic [CNT_W:0]   rob_u, rs_u, lsb_u;

  // Returns {saturated, next_count}; alloc+release together leaves the count alone.
  function automatic logic [CNT_W:0] upd(input logic [CNT_W-1:0] cnt, input logic alloc,
                                         input logic rel, input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (alloc && !rel) begin
      if (cnt >= lim) r = {1'b1, lim};
      else            r = {1'b0, cnt + CNT_W'(1)};
    end else if (rel && !alloc) begin
      if (cnt == '0)  r = {1'b1, {CNT_W{1'b0}}};
      else            r = {1'b0, cnt - CNT_W'(1)};
    end
    return r;
  endfunction

  // The pending registered enable is charged; same-cycle releases are not credited.
  always_comb begin
    rob_full = rst || (({1'b0, rob_cnt_q} + (CNT_W+1)'(bus.instr_rdy_2rob)) >= {1'b0, RobMax});
    rs_full  = rst || (({1'b0, rs_cnt_q} + (CNT_W+1)'(bus.ena_rs)) >= {1'b0, RsMax});
    lsb_full = rst || (({1'b0, lsb_cnt_q} + (CNT_W+1)'(bus.ena_lsb)) >= {1'b0, LsbMax});
    is_full  = rob_full || rs_full || lsb_full;
  end

  always_comb begin
    rob_u     = upd(rob_cnt_q, bus.instr_rdy_2rob, bus.rob_commit, RobMax);
    rs_u      = upd(rs_cnt_q, bus.ena_rs, bus.rs_issue, RsMax);
    lsb_u     = upd(lsb_cnt_q, bus.ena_lsb, bus.lsb_issue, LsbMax);
    rob_cnt_d = rob_cnt_q;
    rs_cnt_d  = rs_cnt_q;
    lsb_cnt_d = lsb_cnt_q;
    err_d     = err_q;
    if (!bus.rdy) begin
      // Dispatcher holds its enables while paused; counting them would double-count.
    end else if (bus.rollback_signal) begin
      rob_cnt_d = '0;
      rs_cnt_d  = '0;
      if (bus.lsb_keep_cnt > LsbMax) begin
        lsb_cnt_d = LsbMax;
        err_d     = 1'b1;
      end else begin
        lsb_cnt_d = bus.lsb_keep_cnt;
      end
    end else begin
      rob_cnt_d = rob_u[CNT_W-1:0];
      rs_cnt_d  = rs_u[CNT_W-1:0];
      lsb_cnt_d = lsb_u[CNT_W-1:0];
      err_d     = err_q || rob_u[CNT_W] || rs_u[CNT_W] || lsb_u[CNT_W] ||
                  (bus.instr_rdy_2rob != (bus.ena_rs || bus.ena_lsb));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_cnt_q <= '0;
      rs_cnt_q  <= '0;
      lsb_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rob_cnt_q <= rob_cnt_d;
      rs_cnt_q  <= rs_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.is_full  = is_full;
  assign bus.rob_full = rob_full;
  assign bus.rs_full  = rs_full;
  assign bus.lsb_full = lsb_full;
  assign bus.rob_cnt  = rob_cnt_q;
  assign bus.rs_cnt   = rs_cnt_q;
  assign bus.lsb_cnt  = lsb_cnt_q;
  assign bus.err_flag = err_q;

`ifdef DSP_STALL_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [2:0]  stall_cause_q, stall_cause_d;

  always_comb begin
    stall_cyc_d   = stall_cyc_q;
    stall_cause_d = stall_cause_q;
    if (bus.rdy && !bus.rollback_signal && is_full) begin
      stall_cyc_d   = stall_cyc_q + 32'd1;
      stall_cause_d = {lsb_full, rs_full, rob_full};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q   <= '0;
      stall_cause_q <= '0;
    end else begin
      stall_cyc_q   <= stall_cyc_d;
      stall_cause_q <= stall_cause_d;
    end
  end

  assign bus.stall_cyc   = stall_cyc_q;
  assign bus.stall_cause = stall_cause_q;
`endif
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Scoreboard bench for dispatch_credit_ctrl: a cycle model pushes expected flags/state per
// driven cycle; each scenario task pops and compares, plus a few direct scenario checks.
module tb_dispatch_credit_ctrl;
  localparam int Size = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_credit_ctrl_if #(.CNT_W(5)) bus ();

  dispatch_credit_ctrl #(
    .ROB_SIZE(16), .RS_SIZE(16), .LSB_SIZE(16), .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  exp_f, obs_f;
    logic [15:0] exp_s, obs_s;
    logic [34:0] exp_x, obs_x;
  } sb_t;

  sb_t sb_q[$];
  int checks = 0;
  int errors = 0;

  int          m_rob = 0, m_rs = 0, m_lsb = 0;
  bit          m_err = 0;
  logic [31:0] m_stall = '0;
  logic [2:0]  m_cause = '0;

  function automatic int nxt(input int c, input bit a, input bit r, inout bit e);
    if (a && !r) begin
      if (c == Size) e = 1'b1;
      else return c + 1;
    end else if (r && !a) begin
      if (c == 0) e = 1'b1;
      else return c - 1;
    end
    return c;
  endfunction

  // Drives one cycle, records model expectation and observed DUT values to the scoreboard.
  task automatic cyc(input bit r, input bit rd, input bit rb, input bit ir, input bit er,
                     input bit el, input bit rc, input bit ri, input bit li,
                     input logic [4:0] keep);
    sb_t e;
    bit fr, fs, fl;
    rst = r; bus.rdy = rd; bus.rollback_signal = rb;
    bus.instr_rdy_2rob = ir; bus.ena_rs = er; bus.ena_lsb = el;
    bus.rob_commit = rc; bus.rs_issue = ri; bus.lsb_issue = li; bus.lsb_keep_cnt = keep;
    #1;
    fr = r || (m_rob + int'(ir) >= Size);
    fs = r || (m_rs + int'(er) >= Size);
    fl = r || (m_lsb + int'(el) >= Size);
    e.exp_f = {fr | fs | fl, fl, fs, fr};
    e.obs_f = {bus.is_full, bus.lsb_full, bus.rs_full, bus.rob_full};
    if (r) begin
      m_rob = 0; m_rs = 0; m_lsb = 0; m_err = 0; m_stall = '0; m_cause = '0;
    end else if (!rd) begin
    end else if (rb) begin
      m_rob = 0; m_rs = 0; m_lsb = int'(keep);
    end else begin
      if (ir != (er | el)) m_err = 1'b1;
      if (fr | fs | fl) begin
        m_stall = m_stall + 32'd1;
        m_cause = {fl, fs, fr};
      end
      m_rob = nxt(m_rob, ir, rc, m_err);
      m_rs  = nxt(m_rs, er, ri, m_err);
      m_lsb = nxt(m_lsb, el, li, m_err);
    end
    e.exp_s = {5'(m_rob), 5'(m_rs), 5'(m_lsb), m_err};
    @(posedge clk);
    #1;
    e.obs_s = {bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt, bus.err_flag};
`ifdef DSP_STALL_STATS_EN
    e.exp_x = {m_stall, m_cause};
    e.obs_x = {bus.stall_cyc, bus.stall_cause};
`else
    e.exp_x = '0;
    e.obs_x = '0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_reset();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    checks++;
    if ({bus.is_full, bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt} !== {1'b1, 15'd0}) begin
      errors++;
      $display("FAIL reset_hold: got full=%b cnts=%0d/%0d/%0d want full=1 cnts=0/0/0",
               bus.is_full, bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.is_full, bus.err_flag} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got full=%b err=%b want 0 0", bus.is_full, bus.err_flag);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL reset_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_fill_rs();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    #1;
    checks++;
    if ({bus.rs_cnt, bus.rs_full, bus.is_full} !== {5'd15, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL fill_rs_15: got cnt=%0d full=%b is_full=%b want 15 1 1",
               bus.rs_cnt, bus.rs_full, bus.is_full);
    end
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    idle();
    checks++;
    if ({bus.rs_cnt, bus.err_flag} !== {5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill_rs_16: got cnt=%0d err=%b want 16 0", bus.rs_cnt, bus.err_flag);
    end
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    checks++;
    if ({bus.rs_cnt, bus.err_flag} !== {5'd16, 1'b1}) begin
      errors++;
      $display("FAIL fill_rs_sat: got cnt=%0d err=%b want 16 1", bus.rs_cnt, bus.err_flag);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL fill_rs_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_simultaneous();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 1, 1, 0, 0, 1, 0, 5'd0);
    checks++;
    if (bus.rs_cnt !== 5'd8) begin
      errors++;
      $display("FAIL simul_hold: got rs_cnt=%0d want 8", bus.rs_cnt);
    end
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    checks++;
    if (bus.rs_cnt !== 5'd9) begin
      errors++;
      $display("FAIL simul_inc: got rs_cnt=%0d want 9", bus.rs_cnt);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL simul_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_pause();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0, 1, 1, 0, 5'd0);
    checks++;
    if (bus.rob_cnt !== 5'd5) begin
      errors++;
      $display("FAIL pause_hold: got rob_cnt=%0d want 5", bus.rob_cnt);
    end
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    checks++;
    if (bus.rob_cnt !== 5'd6) begin
      errors++;
      $display("FAIL pause_resume: got rob_cnt=%0d want 6", bus.rob_cnt);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL pause_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_rollback();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 1, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 1, 1, 0, 0, 5'd0);
    checks++;
    if ({bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt} !== {5'd10, 5'd6, 5'd7}) begin
      errors++;
      $display("FAIL rollback_pre: got %0d/%0d/%0d want 10/6/7",
               bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt);
    end
    cyc(0, 1, 1, 1, 0, 1, 0, 0, 0, 5'd3);
    bus.rollback_signal = 1'b0; bus.instr_rdy_2rob = 1'b0; bus.ena_lsb = 1'b0;
    #1;
    checks++;
    if ({bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt, bus.is_full} !== {5'd0, 5'd0, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL rollback_post: got %0d/%0d/%0d full=%b want 0/0/3 full=0",
               bus.rob_cnt, bus.rs_cnt, bus.lsb_cnt, bus.is_full);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL rollback_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_underflow();
    sb_t e;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0);
    for (int i = 0; i < 3; i++) idle();
    checks++;
    if ({bus.lsb_cnt, bus.err_flag} !== {5'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow: got lsb_cnt=%0d err=%b want 0 1", bus.lsb_cnt, bus.err_flag);
    end
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    checks++;
    if (bus.err_flag !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: got err=%b want 0", bus.err_flag);
    end
    // Rollback straight to a full LSB, then four stalled idle cycles.
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 5'd16);
    for (int i = 0; i < 4; i++) idle();
`ifdef DSP_STALL_STATS_EN
    checks++;
    if ({bus.stall_cyc, bus.stall_cause} !== {32'd4, 3'b100}) begin
      errors++;
      $display("FAIL stall_stats: got cyc=%0d cause=%b want 4 100",
               bus.stall_cyc, bus.stall_cause);
    end
`endif
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL underflow_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  task automatic test_random();
    sb_t e;
    bit er, el, ir;
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 400; i++) begin
      er = ($urandom_range(0, 1) == 1);
      el = ($urandom_range(0, 2) == 0);
      ir = er | el;
      if ($urandom_range(0, 59) == 0) ir = ~ir;
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0,
          ir, er, el, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 16)));
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); checks++;
      if ({e.obs_f, e.obs_s, e.obs_x} !== {e.exp_f, e.exp_s, e.exp_x}) begin
        errors++;
        $display("FAIL random_sb: got f=%b s=%h x=%h want f=%b s=%h x=%h",
                 e.obs_f, e.obs_s, e.obs_x, e.exp_f, e.exp_s, e.exp_x);
      end
    end
  endtask

  initial begin
    bus.rdy = 1'b1; bus.rollback_signal = 1'b0; bus.instr_rdy_2rob = 1'b0;
    bus.ena_rs = 1'b0; bus.ena_lsb = 1'b0; bus.rob_commit = 1'b0;
    bus.rs_issue = 1'b0; bus.lsb_issue = 1'b0; bus.lsb_keep_cnt = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_rs();
    test_simultaneous();
    test_pause();
    test_rollback();
    test_underflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
